// File: rtl/brom_pkg.sv
// Shared definitions for the block-ROM scan sequencer: FSM state encoding and default bus widths.
package brom_pkg;

  localparam int BROM_ADDR_W = 4;
  localparam int BROM_DATA_W = 4;

  // Down-counter width for the drain phase. RD_LAT is limited to 1..3.
  localparam int BROM_DRAIN_CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } brom_state_e;

endpackage

// File: rtl/brom_lat_pipe.sv
// RD_LAT-stage delay line of {valid, index} that tracks each issued ROM address until its data returns.
module brom_lat_pipe #(
  parameter int RD_LAT = 1,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [RD_LAT-1:0]            valid_q, valid_d;
  logic [RD_LAT-1:0][IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    valid_d    = valid_q;
    idx_d      = idx_q;
    valid_d[0] = in_valid;
    idx_d[0]   = in_idx;
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      idx_d[i]   = idx_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_idx   = idx_q[RD_LAT-1];

endmodule

// File: rtl/brom_scan_max.sv
// Block-ROM scan sequencer: issues every address, absorbs read latency, reduces data to max (and index).
// Optional min tracking is enabled by defining BROM_MIN_TRACK_EN.
//
//   state   | meaning
//   S_IDLE  | waiting for start; result registers hold the previous scan
//   S_ISSUE | rom_en=1, rom_addr steps 0..DEPTH-1
//   S_DRAIN | rom_en=0, RD_LAT cycles for the last word to return
//   S_DONE  | one-cycle done pulse, result is final
module brom_scan_max
  import brom_pkg::*;
#(
  parameter int ADDR_W = BROM_ADDR_W,
  parameter int DATA_W = BROM_DATA_W,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_idx
`ifdef BROM_MIN_TRACK_EN
  ,
  output logic [DATA_W-1:0] min_val,
  output logic [ADDR_W-1:0] min_idx
`endif
);

  localparam logic [ADDR_W-1:0]           LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [BROM_DRAIN_CNT_W-1:0] DRAIN_LOAD = BROM_DRAIN_CNT_W'(RD_LAT - 1);

  brom_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]           rom_addr_q, rom_addr_d;
  logic [BROM_DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic                        seen_q, seen_d;
  logic [DATA_W-1:0]           max_val_q, max_val_d;
  logic [ADDR_W-1:0]           max_idx_q, max_idx_d;
`ifdef BROM_MIN_TRACK_EN
  logic [DATA_W-1:0]           min_val_q, min_val_d;
  logic [ADDR_W-1:0]           min_idx_q, min_idx_d;
`endif

  logic              ret_valid;
  logic [ADDR_W-1:0] ret_idx;

  brom_lat_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (ADDR_W)
  ) u_lat_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rom_en),
    .in_idx    (rom_addr_q),
    .out_valid (ret_valid),
    .out_idx   (ret_idx)
  );

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    drain_cnt_d = drain_cnt_q;
    seen_d      = seen_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ISSUE;
          rom_addr_d = '0;
          seen_d     = 1'b0;
        end
      end
      S_ISSUE: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          rom_addr_d = rom_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ret_valid) begin
      seen_d = 1'b1;
    end
  end

  // Result registers keep the previous scan until the first word of the new scan returns.
  always_comb begin
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
`ifdef BROM_MIN_TRACK_EN
    min_val_d = min_val_q;
    min_idx_d = min_idx_q;
`endif
    if (ret_valid) begin
      if (!seen_q || (rom_data > max_val_q)) begin
        max_val_d = rom_data;
        max_idx_d = ret_idx;
      end
`ifdef BROM_MIN_TRACK_EN
      if (!seen_q || (rom_data < min_val_q)) begin
        min_val_d = rom_data;
        min_idx_d = ret_idx;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      drain_cnt_q <= '0;
      seen_q      <= 1'b0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
`ifdef BROM_MIN_TRACK_EN
      min_val_q   <= '0;
      min_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      drain_cnt_q <= drain_cnt_d;
      seen_q      <= seen_d;
      max_val_q   <= max_val_d;
      max_idx_q   <= max_idx_d;
`ifdef BROM_MIN_TRACK_EN
      min_val_q   <= min_val_d;
      min_idx_q   <= min_idx_d;
`endif
    end
  end

  assign rom_en   = (state_q == S_ISSUE);
  assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign rom_addr = rom_addr_q;
  assign max_val  = max_val_q;
  assign max_idx  = max_idx_q;
`ifdef BROM_MIN_TRACK_EN
  assign min_val  = min_val_q;
  assign min_idx  = min_idx_q;
`endif

endmodule
